// File: rtl/bit_serial_adder_seq.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first, registered carry.
// Optional subtract mode under `BIT_SERIAL_SUB_EN (adds input_sub port).

module single_bit_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module bit_serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             input_clock,
  input  logic             input_reset_n,
  input  logic             input_start,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic             input_carry,
`ifdef BIT_SERIAL_SUB_EN
  input  logic             input_sub,
`endif
  output logic             output_busy,
  output logic             output_done,
  output logic [WIDTH-1:0] output_sum,
  output logic             output_carry,
  output logic             output_overflow
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a start is accepted on any edge where input_start=1 and the
  // FSM is not in SHIFT; the result is valid while output_done=1 and holds
  // until the next accept.
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_carry_msb;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_accept;
  logic               w_last;
  logic               w_fa_sum;
  logic               w_fa_carry;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_c_load;
  logic [WIDTH-1:0]   w_sum_shift;

  assign w_accept = input_start && (r_state != ST_SHIFT);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef BIT_SERIAL_SUB_EN
  // Subtraction as A + ~B + 1; carry-out of 1 then means no borrow.
  assign w_b_load = input_sub ? ~input_b : input_b;
  assign w_c_load = input_sub ? 1'b1 : input_carry;
`else
  assign w_b_load = input_b;
  assign w_c_load = input_carry;
`endif

  single_bit_full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_sum),
    .o_c (w_fa_carry)
  );

  always_comb begin
    w_sum_shift            = r_sum >> 1;
    w_sum_shift[WIDTH-1]   = w_fa_sum;
  end

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) r_state <= ST_IDLE;
    else                r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (input_start) w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_last)      w_next_state = ST_DONE;
      ST_DONE:  w_next_state = input_start ? ST_SHIFT : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge input_clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_msb <= 1'b0;
      r_cnt       <= '0;
    end else if (w_accept) begin
      r_a     <= input_a;
      r_b     <= w_b_load;
      r_carry <= w_c_load;
      r_cnt   <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_shift;
      r_carry <= w_fa_carry;
      r_cnt   <= r_cnt + 1'b1;
      // Carry into the MSB is the flop value before the last bit updates it.
      if (w_last) r_carry_msb <= r_carry;
    end
  end

  assign output_busy     = (r_state == ST_SHIFT);
  assign output_done     = (r_state == ST_DONE);
  assign output_sum      = r_sum;
  assign output_carry    = r_carry;
  assign output_overflow = r_carry_msb ^ r_carry;

endmodule

// File: tb/tb_bit_serial_adder_seq.sv
// Randomized scoreboard bench for bit_serial_adder_seq (WIDTH = 8), with
// directed cases for back-to-back starts, reset abort and optional subtract.

module tb_bit_serial_adder_seq;
  localparam int W  = 8;
  localparam int EW = 32 + 2 + W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  bit_serial_adder_seq #(.WIDTH(W)) dut (
    .input_clock     (clk),
    .input_reset_n   (rst_n),
    .input_start     (start),
    .input_a         (a),
    .input_b         (b),
    .input_carry     (cin),
`ifdef BIT_SERIAL_SUB_EN
    .input_sub       (sub),
`endif
    .output_busy     (busy),
    .output_done     (done),
    .output_sum      (sum),
    .output_carry    (cout),
    .output_overflow (ovf)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from range check.
  task automatic push_exp(input logic [W-1:0] ea, input logic [W-1:0] eb,
                          input logic ec, input logic es, input int edge_no);
    longint ua, ub, uc, tot, sa, sb, stot;
    logic [W-1:0] s;
    logic c, o;
    ua = longint'(ea);
    ub = es ? longint'(~eb) : longint'(eb);
    uc = es ? 1 : longint'(ec);
    tot = ua + ub + uc;
    s = tot[W-1:0];
    c = (tot >= (64'sd1 <<< W));
    sa = (ua >= (64'sd1 <<< (W-1))) ? ua - (64'sd1 <<< W) : ua;
    sb = (ub >= (64'sd1 <<< (W-1))) ? ub - (64'sd1 <<< W) : ub;
    stot = sa + sb + uc;
    o = (stot > (64'sd1 <<< (W-1)) - 1) || (stot < -(64'sd1 <<< (W-1)));
    exp_q.push_back({32'(edge_no + W), c, o, s});
  endtask

  // driver: accept happens at the rising edge following the drive
  task automatic do_op(input logic [W-1:0] da, input logic [W-1:0] db,
                       input logic dc, input logic ds);
    @(negedge clk);
    a = da; b = db; cin = dc; sub = ds; start = 1'b1;
    push_exp(da, db, dc, ds, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    repeat (W + 1) @(negedge clk);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, longint'(e[EW-1:W+2]));
        check("sum", sum, e[W-1:0]);
        check("carry", cout, e[W+1]);
        check("overflow", ovf, e[W]);
        check("busy_in_done", busy, 0);
      end
    end
  end

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", cout, 0);
    check("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h00, 1'b1, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);

    // start held high: back-to-back accepts from DONE, operand noise ignored
    @(negedge clk);
    start = 1'b1;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    push_exp(a, b, cin, 1'b0, cyc + 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      for (int j = 0; j < W; j++) begin
        @(negedge clk);
        check("busy_hold", busy, 1);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (k < 2) push_exp(a, b, cin, 1'b0, cyc + 1);
      else start = 1'b0;
    end
    repeat (W + 2) @(negedge clk);

    // reset in the middle of an operation: no done, outputs cleared at once
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_carry", cout, 0);
    check("abort_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    do_op(8'h01, 8'h02, 1'b0, 1'b0);

`ifdef BIT_SERIAL_SUB_EN
    do_op(8'h10, 8'h20, 1'b0, 1'b1);
    do_op(8'h80, 8'h01, 1'b1, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      logic rs;
`ifdef BIT_SERIAL_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), rs);
    end

    repeat (4) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
